// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared constants, op encodings and FSM state type for the
//                iterative 32-bit multiply/divide unit.
//  Config      : MULDIV_DIV_EN (see muldiv_unit) selects the divide datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int STEPS = 32;

   // Result written to LO when the divisor is zero
   localparam logic [XLEN-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

   // Final value of the 6-bit step counter before leaving RUN
   localparam logic [5:0] CNT_LAST = 6'(STEPS - 1);

   // Operation encodings on i_op
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // Signed ops work on operand magnitudes and fix the sign afterwards
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sign_fix
//  Description : Combinational sign handling: absolute value of both operands
//                at acceptance, and conditional negation of the 64-bit result
//                (either as a whole, or as two independent 32-bit halves for
//                the quotient/remainder pair).
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sign_fix
   import muldiv_pkg::*;
(
   input  logic              i_signed,
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   output logic [XLEN-1:0]   o_mag_a,
   output logic [XLEN-1:0]   o_mag_b,
   output logic              o_neg_a,
   output logic              o_neg_b,
   input  logic [2*XLEN-1:0] i_wide,
   input  logic              i_split,
   input  logic              i_neg_lo,
   input  logic              i_neg_hi,
   output logic [2*XLEN-1:0] o_wide
);

   // Operand magnitudes; the most negative value maps to 2^31 as unsigned
   always_comb begin
      o_neg_a = i_signed & i_a[XLEN-1];
      o_neg_b = i_signed & i_b[XLEN-1];
      o_mag_a = o_neg_a ? (~i_a + 1'b1) : i_a;
      o_mag_b = o_neg_b ? (~i_b + 1'b1) : i_b;
   end

   logic [XLEN-1:0] w_hi;
   logic [XLEN-1:0] w_lo;

   // Split mode negates HI (remainder) and LO (quotient) separately
   always_comb begin
      w_hi = i_neg_hi ? (~i_wide[2*XLEN-1:XLEN] + 1'b1) : i_wide[2*XLEN-1:XLEN];
      w_lo = i_neg_lo ? (~i_wide[XLEN-1:0] + 1'b1)      : i_wide[XLEN-1:0];
      if (i_split) begin
         o_wide = {w_hi, w_lo};
      end else begin
         o_wide = i_neg_lo ? (~i_wide + 1'b1) : i_wide;
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32x32 multiply / 32/32 divide unit with HI/LO
//                result registers. One shift-add or restoring shift-subtract
//                step per cycle, 34 edges from accepting edge to o_done.
//  Config      : MULDIV_DIV_EN defined   -> DIV/DIVU implemented
//                MULDIV_DIV_EN undefined -> DIV/DIVU rejected as illegal
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_busA,
   input  logic [XLEN-1:0] i_busB,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo,
   output logic            o_illegal
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [5:0]        r_cnt;
   logic [2*XLEN-1:0] r_acc;       // {partial HI, multiplier} or {remainder, quotient}
   logic [XLEN-1:0]   r_b;         // multiplicand or divisor magnitude
   logic              r_neg_res;   // product / quotient must be negated
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_done;
   logic              r_illegal;

   logic              w_op_mul;
   logic              w_op_div;
   logic              w_op_mt;
   logic              w_iter;
   logic              w_signed;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_neg_a;
   logic              w_neg_b;
   logic              w_split;
   logic              w_neg_hi;
   logic [2*XLEN-1:0] w_fix;
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_nxt;
   logic [2*XLEN-1:0] w_step_nxt;

   assign w_op_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
   assign w_op_mt  = (i_op == OP_MTHI) || (i_op == OP_MTLO);
   assign w_iter   = w_op_mul || w_op_div;
   assign w_signed = op_is_signed(i_op);

   // Shift-add multiply step: conditional add into the upper half, then shift right
   assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : '0)};
   assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
   logic              r_is_div;
   logic              r_neg_a;     // remainder follows the dividend's sign
   logic              r_b_zero;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_trial;
   logic [2*XLEN-1:0] w_div_nxt;

   assign w_op_div = (i_op == OP_DIV) || (i_op == OP_DIVU);

   // Restoring divide step: shift {rem,quo} left, keep the trial subtract if non-negative
   assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
   assign w_div_trial = w_div_shift - {1'b0, r_b};
   assign w_div_nxt   = w_div_trial[XLEN]
                      ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                      : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
   assign w_step_nxt  = r_is_div ? w_div_nxt : w_mul_nxt;
   assign w_split     = r_is_div;
   assign w_neg_hi    = r_neg_a;
`else
   assign w_op_div   = 1'b0;
   assign w_step_nxt = w_mul_nxt;
   assign w_split    = 1'b0;
   assign w_neg_hi   = 1'b0;
`endif

   muldiv_sign_fix u_sign_fix (
      .i_signed (w_signed),
      .i_a      (i_busA),
      .i_b      (i_busB),
      .o_mag_a  (w_mag_a),
      .o_mag_b  (w_mag_b),
      .o_neg_a  (w_neg_a),
      .o_neg_b  (w_neg_b),
      .i_wide   (r_acc),
      .i_split  (w_split),
      .i_neg_lo (r_neg_res),
      .i_neg_hi (w_neg_hi),
      .o_wide   (w_fix)
   );

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and busy flag
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start && w_iter) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            o_busy      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand latch, iteration datapath, HI/LO write-back and status pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_b       <= '0;
         r_neg_res <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_is_div  <= 1'b0;
         r_neg_a   <= 1'b0;
         r_b_zero  <= 1'b0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (w_iter) begin
                     r_acc     <= {{XLEN{1'b0}}, w_mag_a};
                     r_b       <= w_mag_b;
                     r_neg_res <= w_neg_a ^ w_neg_b;
                     r_cnt     <= '0;
`ifdef MULDIV_DIV_EN
                     r_is_div  <= w_op_div;
                     r_neg_a   <= w_neg_a;
                     r_b_zero  <= (i_busB == '0);
`endif
                  end else if (w_op_mt) begin
                     if (i_op == OP_MTHI) begin
                        r_hi <= i_busA;
                     end else begin
                        r_lo <= i_busA;
                     end
                     r_done <= 1'b1;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_acc <= w_step_nxt;
               if (r_cnt != CNT_LAST) begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            ST_FIX: begin
`ifdef MULDIV_DIV_EN
               if (r_is_div && r_b_zero) begin
                  r_hi <= w_fix[2*XLEN-1:XLEN];
                  r_lo <= DIV_BY_ZERO_LO;
               end else begin
                  r_hi <= w_fix[2*XLEN-1:XLEN];
                  r_lo <= w_fix[XLEN-1:0];
               end
`else
               r_hi <= w_fix[2*XLEN-1:XLEN];
               r_lo <= w_fix[XLEN-1:0];
`endif
               r_done <= 1'b1;
               r_cnt  <= '0;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign o_done    = r_done;
   assign o_illegal = r_illegal;
   assign o_hi      = r_hi;
   assign o_lo      = r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; data width fixed at 32.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  request strobe; sampled at a rising edge only when o_busy=0.
REQ-005 i_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 illegal.
REQ-006 i_busA  in  32  operand A (rs): multiplicand, dividend, or MTHI/MTLO source.
REQ-007 i_busB  in  32  operand B (rt): multiplier or divisor.
REQ-008 o_busy  out  1  high while an iterative operation is in progress.
REQ-009 o_done  out  1  one-cycle pulse when HI/LO have been updated.
REQ-010 o_hi  out  32  HI register, registered output.
REQ-011 o_lo  out  32  LO register, registered output.
REQ-012 o_illegal  out  1  one-cycle pulse for a rejected op.

Function
REQ-013 States: IDLE, RUN, FIX.
- IDLE->RUN on accepted MULT/MULTU/DIV/DIVU.
- RUN->FIX after exactly 32 iterations.
- FIX->IDLE unconditionally.
REQ-014 On acceptance, latch operand magnitudes, signs, op and a 6-bit step counter; from the next cycle o_busy=1.
REQ-015 RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
- Counter 0..31, no wrap.
- Unsigned ops use raw operands; signed ops use absolute values.
REQ-016 FIX: apply sign correction and write the 64-bit result in one cycle.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder.
- o_done=1 and o_busy=0 after that edge.
- Total latency: start edge to o_done = 34 edges.
REQ-017 Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-018 Divide by zero: HI = dividend (as given), LO = 0xFFFFFFFF; still takes the full latency.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-020 MTHI/MTLO in IDLE: write the target from i_busA at the accepting edge; o_done pulses after that edge; o_busy stays 0.
REQ-021 i_start while o_busy=1 is ignored: no state change, no o_illegal.
REQ-022 Illegal i_op in IDLE: no state change; o_illegal pulses one cycle.
REQ-023 HI/LO hold their values at all times except at the FIX or MTHI/MTLO write edge.

Reset
REQ-024 i_rst_n=0 forces immediately: state IDLE, counter 0, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_illegal=0.
REQ-025 Reset during RUN/FIX abandons the operation without a partial HI/LO write; first acceptance is possible on the first edge after release.

Configuration
REQ-026 Macro MULDIV_DIV_EN:
- Defined: DIV/DIVU are implemented as above.
- Undefined: divide datapath is absent; DIV/DIVU are treated as illegal per REQ-022, and HI/LO are unchanged.

Structure
REQ-027 Package muldiv_pkg holds:
- op encodings and state enum;
- constant XLEN=32 and STEPS=32;
- DIV_BY_ZERO_LO = 32'hFFFFFFFF.
REQ-028 One sub-module, muldiv_sign_fix: combinational abs/negate of 32/64-bit values for operand prep and FIX; all sequencing stays in muldiv_unit.

Verification
REQ-029 MULT A=0xFFFFFFFF, B=2 -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFFE, one o_done pulse.
REQ-030 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI=7, LO=0xFFFFFFFF.
REQ-032 Start MULTU 3*5, pulse i_start with MTHI at cycle 5 -> second request ignored; final HI=0, LO=15.
REQ-033 Reset asserted mid-RUN (cycle 10) after preloading HI=0x1234 via MTHI -> HI=LO=0, busy=0; a new MULT after release completes correctly.
REQ-034 Build without MULDIV_DIV_EN, issue DIV -> o_illegal pulses, o_busy stays 0, HI/LO unchanged.
